// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA raster counters with registered sync, visible flag,
// blanked colour and frame-start pulse, all aligned one Clock after the counters.
module vga_timing_generator #(
  parameter int CLOCK_DIV = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iR,
  input  logic       iG,
  input  logic       iB,
  output logic       oR,
  output logic       oG,
  output logic       oB,
  output logic       oHSync,
  output logic       oVSync,
  output logic [9:0] oCol,
  output logic [9:0] oRow,
  output logic       oVisible,
  output logic       oFrameStart
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLOCK_DIV > 1 ? $clog2(CLOCK_DIV) : 1;
  logic [DW-1:0] div;
  logic tick, h_end, v_end, h_sync, v_sync, visible;
  always_comb begin
    tick    = div == DW'(CLOCK_DIV - 1);
    h_end   = oCol == 10'(H_TOTAL - 1);
    v_end   = oRow == 10'(V_TOTAL - 1);
    h_sync  = oCol >= 10'(H_VISIBLE + H_FRONT) && oCol <= 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    v_sync  = oRow >= 10'(V_VISIBLE + V_FRONT) && oRow <= 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    visible = oCol < 10'(H_VISIBLE) && oRow < 10'(V_VISIBLE);
  end
  // Outputs are registered from the pre-edge counters so sync and colour stay aligned.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      div         <= '0;
      oCol        <= '0;
      oRow        <= '0;
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oVisible    <= 1'b0;
      oFrameStart <= 1'b0;
      {oR, oG, oB} <= 3'b000;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        oCol <= h_end ? '0 : oCol + 10'd1;
        if (h_end) oRow <= v_end ? '0 : oRow + 10'd1;
      end
      oHSync      <= !h_sync;
      oVSync      <= !v_sync;
      oVisible    <= visible;
      oFrameStart <= tick && h_end && v_end;
      {oR, oG, oB} <= visible ? {iR, iG, iB} : 3'b000;
    end
  end
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: scaled-down raster (16x9 totals, 2 Clocks/pixel) checked
// against a cycle model scoreboard, a checkpoint table and window-count sequences.
module tb_vga_timing_generator;
  localparam int CD = 2, HV = 8, HF = 2, HS = 3, HB = 3, VV = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
  localparam int FRAME = CD * HT * VT;
  logic Clock = 0, Reset = 1, mode = 0;
  logic iR, iG, iB, oR, oG, oB, oHSync, oVSync, oVisible, oFrameStart;
  logic [9:0] oCol, oRow;
  int n_cmp = 0, n_bad = 0, e = 0;
  int m_d = 0, m_h = 0, m_v = 0;

  typedef struct packed {
    logic [9:0] col, row;
    logic hs, vs, vis, fs;
    logic [2:0] rgb;
  } out_t;
  typedef struct {
    int   e;
    out_t o;
  } vec_t;
  out_t sb[$];
  vec_t tab[15];

  vga_timing_generator #(
    .CLOCK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iR(iR), .iG(iG), .iB(iB),
    .oR(oR), .oG(oG), .oB(oB), .oHSync(oHSync), .oVSync(oVSync),
    .oCol(oCol), .oRow(oRow), .oVisible(oVisible), .oFrameStart(oFrameStart)
  );

  always #5 Clock = ~Clock;
  assign iR = mode ? (oCol == 10'd0) : 1'b1;
  assign iG = mode ? oRow[0] : 1'b1;
  assign iB = mode ? oCol[1] : 1'b1;

  function automatic out_t model(int d, int h, int v, logic rst, logic [2:0] rgb_in);
    out_t o;
    logic t;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (rst) return o;
    t = d == CD - 1;
    o.col = 10'(t ? (h == HT - 1 ? 0 : h + 1) : h);
    o.row = 10'((t && h == HT - 1) ? (v == VT - 1 ? 0 : v + 1) : v);
    o.hs  = !(h >= HV + HF && h < HV + HF + HS);
    o.vs  = !(v >= VV + VF && v < VV + VF + VS);
    o.vis = h < HV && v < VV;
    o.rgb = o.vis ? rgb_in : 3'b000;
    o.fs  = t && h == HT - 1 && v == VT - 1;
    return o;
  endfunction

  function automatic out_t dut_out();
    return {oCol, oRow, oHSync, oVSync, oVisible, oFrameStart, oR, oG, oB};
  endfunction

  always @(posedge Clock) begin
    sb.push_back(model(m_d, m_h, m_v, Reset, mode ? {m_h == 0, m_v[0], m_h[1]} : 3'b111));
    if (Reset) begin
      m_d <= 0;
      m_h <= 0;
      m_v <= 0;
    end else begin
      m_d <= m_d == CD - 1 ? 0 : m_d + 1;
      if (m_d == CD - 1) begin
        m_h <= m_h == HT - 1 ? 0 : m_h + 1;
        if (m_h == HT - 1) m_v <= m_v == VT - 1 ? 0 : m_v + 1;
      end
    end
  end

  always @(negedge Clock) begin
    out_t want, got;
    if (sb.size() != 0) begin
      want = sb.pop_front();
      got  = dut_out();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL sb t=%0t got %h want %h", $time, got, want);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      while (e < tab[i].e) begin
        @(posedge Clock);
        e++;
      end
      @(negedge Clock);
      chk($sformatf("vec%0d_e%0d", i, tab[i].e), 32'(dut_out()), 32'(tab[i].o));
    end
  endtask

  initial begin
    int fs_n, rgb_n, blank_bad, hs_n, vs_n, vis_n, r_n, rise_bad, found;
    logic prev_r;
    logic [9:0] c1, c2;
    tab[0]  = '{2,   '{10'd1,  10'd0, 1, 1, 1, 0, 3'b111}};
    tab[1]  = '{16,  '{10'd8,  10'd0, 1, 1, 1, 0, 3'b111}};
    tab[2]  = '{17,  '{10'd8,  10'd0, 1, 1, 0, 0, 3'b000}};
    tab[3]  = '{21,  '{10'd10, 10'd0, 0, 1, 0, 0, 3'b000}};
    tab[4]  = '{26,  '{10'd13, 10'd0, 0, 1, 0, 0, 3'b000}};
    tab[5]  = '{27,  '{10'd13, 10'd0, 1, 1, 0, 0, 3'b000}};
    tab[6]  = '{32,  '{10'd0,  10'd1, 1, 1, 0, 0, 3'b000}};
    tab[7]  = '{33,  '{10'd0,  10'd1, 1, 1, 1, 0, 3'b111}};
    tab[8]  = '{128, '{10'd0,  10'd4, 1, 1, 0, 0, 3'b000}};
    tab[9]  = '{161, '{10'd0,  10'd5, 1, 0, 0, 0, 3'b000}};
    tab[10] = '{224, '{10'd0,  10'd7, 1, 0, 0, 0, 3'b000}};
    tab[11] = '{225, '{10'd0,  10'd7, 1, 1, 0, 0, 3'b000}};
    tab[12] = '{287, '{10'd15, 10'd8, 1, 1, 0, 0, 3'b000}};
    tab[13] = '{288, '{10'd0,  10'd0, 1, 1, 0, 1, 3'b000}};
    tab[14] = '{289, '{10'd0,  10'd0, 1, 1, 1, 0, 3'b111}};

    repeat (5) @(posedge Clock);
    @(negedge Clock);
    chk("reset_hold", 32'(dut_out()), 32'(out_t'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000})));
    Reset = 0;
    e = 0;
    run_table(0, 14);

    fs_n = 0; rgb_n = 0; blank_bad = 0; hs_n = 0; vs_n = 0; vis_n = 0;
    repeat (FRAME) begin
      @(posedge Clock);
      @(negedge Clock);
      fs_n  += int'(oFrameStart);
      rgb_n += int'({oR, oG, oB} == 3'b111);
      blank_bad += int'({oR, oG, oB} != 3'b000 && !oVisible);
      hs_n  += int'(!oHSync);
      vs_n  += int'(!oVSync);
      vis_n += int'(oVisible);
    end
    chk("frame_start_count", 32'(fs_n), 32'd1);
    chk("rgb_on_count", 32'(rgb_n), 32'(CD * HV * VV));
    chk("colour_in_blank", 32'(blank_bad), 32'd0);
    chk("hsync_low_count", 32'(hs_n), 32'(CD * HS * VT));
    chk("vsync_low_count", 32'(vs_n), 32'(CD * HT * VS));
    chk("visible_count", 32'(vis_n), 32'(CD * HV * VV));

    mode = 1;
    @(posedge Clock);
    @(negedge Clock);
    r_n = 0; rise_bad = 0; prev_r = oR; c1 = oCol; c2 = oCol;
    repeat (FRAME) begin
      @(posedge Clock);
      @(negedge Clock);
      r_n += int'(oR);
      if (oR && !prev_r && !(c1 == 10'd0 && c2 != 10'd0)) rise_bad++;
      prev_r = oR;
      c2 = c1;
      c1 = oCol;
    end
    chk("red_high_count", 32'(r_n), 32'(CD * VV));
    chk("red_rise_align", 32'(rise_bad), 32'd0);

    mode = 0;
    found = 0;
    for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (oRow == 10'd2 && oCol == 10'd5) found = 1;
    end
    chk("midreset_reach", 32'(found), 32'd1);
    Reset = 1;
    @(posedge Clock);
    @(negedge Clock);
    chk("midreset_state", 32'(dut_out()), 32'(out_t'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000})));
    Reset = 0;
    e = 0;
    run_table(0, 7);

    @(posedge Clock);
    @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
